// File: rtl/exec_sequencer_pkg.sv
// exec_sequencer_pkg: destination-type and opcode constants shared by the sequencer and its exec units
package exec_sequencer_pkg;
    localparam int DST_TYPE_WIDTH = 3;
    localparam logic [DST_TYPE_WIDTH-1:0] DST_RT    = 3'd1;
    localparam logic [DST_TYPE_WIDTH-1:0] DST_RD    = 3'd2;
    localparam logic [DST_TYPE_WIDTH-1:0] DST_PC    = 3'd3;
    localparam logic [DST_TYPE_WIDTH-1:0] DST_MEM_L = 3'd4;
    localparam logic [DST_TYPE_WIDTH-1:0] DST_MEM_S = 3'd5;
    localparam logic [5:0] OP_RTYPE      = 6'h00;
    localparam logic [5:0] OP_J          = 6'h02;
    localparam logic [5:0] OP_JAL        = 6'h03;
    localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
endpackage

// File: rtl/exec_sequencer_next_pc_calc.sv
// exec_sequencer_next_pc_calc: combinational pc+4 / taken-branch / jump target selection
// Ports: pc (current address), target (ir[25:0]), jump, take_branch -> pc_plus4, next_pc
module exec_sequencer_next_pc_calc (
    input  logic [31:0] pc,
    input  logic [25:0] target,
    input  logic        jump,
    input  logic        take_branch,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);
    logic [31:0] br_pc;
    logic [31:0] jmp_pc;
    assign pc_plus4 = pc + 32'd4;
    assign br_pc    = pc_plus4 + {{14{target[15]}}, target[15:0], 2'b00};
    assign jmp_pc   = {pc_plus4[31:28], target, 2'b00};
    assign next_pc  = jump ? jmp_pc : take_branch ? br_pc : pc_plus4;
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multicycle fetch/decode/exec/mem/writeback control FSM for the CPU core
// Ports: clk/clr/run control; halted/err status; pc; imem req/ack fetch port; ir;
//        i_/r_ exec unit en/finished/res/dst; rt_data; rf write port; dmem req/ack data port
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          EXEC_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      run,
    output logic                      halted,
    output logic                      err,
    output logic [31:0]               pc,
    output logic                      imem_req,
    output logic [31:0]               imem_addr,
    input  logic                      imem_ack,
    input  logic [31:0]               imem_rdata,
    output logic [31:0]               ir,
    output logic                      i_en,
    output logic                      r_en,
    input  logic                      i_finished,
    input  logic                      r_finished,
    input  logic [31:0]               i_res,
    input  logic [31:0]               r_res,
    input  logic [DST_TYPE_WIDTH-1:0] i_dst,
    input  logic [DST_TYPE_WIDTH-1:0] r_dst,
    input  logic [31:0]               rt_data,
    output logic                      rf_we,
    output logic [4:0]                rf_waddr,
    output logic [31:0]               rf_wdata,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [31:0]               dmem_addr,
    output logic [31:0]               dmem_wdata,
    input  logic                      dmem_ack,
    input  logic [31:0]               dmem_rdata
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
    localparam int CW = $clog2(EXEC_TIMEOUT + 1);
    state_e                    state_q, state_d;
    logic [31:0]               pc_q, pc_d, ir_q, ir_d, res_q, res_d;
    logic [DST_TYPE_WIDTH-1:0] dst_q, dst_d, fin_dst;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic [5:0]                op;
    logic                      is_r, is_jmp, is_jal, fin, is_store, wr;
    logic [31:0]               pc_plus4, next_pc;
    assign op       = ir_q[31:26];
    assign is_r     = op == OP_RTYPE;
    assign is_jal   = op == OP_JAL;
    assign is_jmp   = op == OP_J || is_jal;
    assign fin      = is_r ? r_finished : i_finished;
    assign fin_dst  = is_r ? r_dst : i_dst;
    assign is_store = dst_q == DST_MEM_S;
    exec_sequencer_next_pc_calc u_next_pc (
        .pc          (pc_q),
        .target      (ir_q[25:0]),
        .jump        (is_jmp),
        .take_branch (dst_q == DST_PC && res_q[0]),
        .pc_plus4    (pc_plus4),
        .next_pc     (next_pc)
    );
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        res_d   = res_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE:   state_d = run ? S_FETCH : S_IDLE;
            S_FETCH: begin
                ir_d    = imem_ack ? imem_rdata : ir_q;
                state_d = imem_ack ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                cnt_d   = '0;
                state_d = (is_r && ir_q[5:0] == FUNCT_SYSCALL) ? S_HALT : is_jmp ? S_WB : S_EXEC;
            end
            S_EXEC: begin
                if (fin) begin
                    res_d   = is_r ? r_res : i_res;
                    dst_d   = fin_dst;
                    state_d = (fin_dst == DST_MEM_L || fin_dst == DST_MEM_S) ? S_MEM : S_WB;
                end else if (cnt_q == CW'(EXEC_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MEM: begin
                // the loaded word replaces the address so WB writes it back
                res_d   = (dmem_ack && !is_store) ? dmem_rdata : res_q;
                state_d = dmem_ack ? S_WB : S_MEM;
            end
            S_WB: begin
                pc_d    = next_pc;
                state_d = run ? S_FETCH : S_IDLE;
            end
            default:  state_d = S_HALT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            res_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            res_q   <= res_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    // dst_q is stale for J/JAL, so jumps are resolved from the opcode first
    assign wr         = is_jal || (!is_jmp && (dst_q == DST_RT || dst_q == DST_RD || dst_q == DST_MEM_L));
    assign rf_waddr   = is_jal ? 5'd31 : dst_q == DST_RD ? ir_q[15:11] : ir_q[20:16];
    assign rf_wdata   = is_jal ? pc_plus4 : res_q;
    assign rf_we      = state_q == S_WB && wr && rf_waddr != 5'd0;
    assign halted     = state_q == S_HALT;
    assign err        = err_q;
    assign pc         = pc_q;
    assign imem_req   = state_q == S_FETCH;
    assign imem_addr  = pc_q;
    assign ir         = ir_q;
    assign i_en       = state_q == S_EXEC && !is_r;
    assign r_en       = state_q == S_EXEC && is_r;
    assign dmem_req   = state_q == S_MEM;
    assign dmem_we    = dmem_req && is_store;
    assign dmem_addr  = res_q;
    assign dmem_wdata = rt_data;
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: table-driven directed test of exec_sequencer with multicycle corner sequences
module tb_exec_sequencer;
    import exec_sequencer_pkg::*;
    logic        clk = 1'b0, clr = 1'b1, run = 1'b0;
    logic        halted, err, imem_req, i_en, r_en, rf_we, dmem_req, dmem_we;
    logic [31:0] pc, imem_addr, ir, rf_wdata, dmem_addr, dmem_wdata;
    logic [4:0]  rf_waddr;
    logic        imem_ack = 1'b0, i_finished = 1'b0, r_finished = 1'b0, dmem_ack = 1'b0;
    logic [31:0] imem_rdata = '0, i_res = '0, r_res = '0, dmem_rdata = '0;
    logic [31:0] rt_data = 32'h1234_5678;
    logic [DST_TYPE_WIDTH-1:0] i_dst = '0, r_dst = '0;
    int n_checks = 0, n_fail = 0;
    int we_cnt = 0, i_cnt = 0, r_cnt = 0;
    logic [4:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] res;
        logic [2:0]  dst;
        logic [1:0]  unit;
        logic [1:0]  mem;
        logic [31:0] rdata;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] npc;
        logic        drop_run;
    } vec_t;
    vec_t vecs [12];
    exec_sequencer dut (
        .clk(clk), .clr(clr), .run(run), .halted(halted), .err(err), .pc(pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .i_en(i_en), .r_en(r_en), .i_finished(i_finished), .r_finished(r_finished),
        .i_res(i_res), .r_res(r_res), .i_dst(i_dst), .r_dst(r_dst), .rt_data(rt_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (rf_we) begin
            we_cnt++;
            last_waddr = rf_waddr;
            last_wdata = rf_wdata;
        end
        if (i_en) i_cnt++;
        if (r_en) r_cnt++;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic sig(input int sel);
        return sel == 0 ? imem_req : sel == 1 ? (i_en | r_en) : dmem_req;
    endfunction
    task automatic wait_for(input int sel, input string name);
        for (int k = 0; k < 50 && !sig(sel); k++) tick();
        chk({name, "_wait"}, {31'd0, sig(sel)}, 32'd1);
    endtask
    task automatic fetch(input logic [31:0] instr, input string name);
        wait_for(0, name);
        tick();
        tick();
        imem_ack = 1'b1;
        imem_rdata = instr;
        tick();
        imem_ack = 1'b0;
    endtask
    task automatic finish_exec(input logic [1:0] unit, input logic [31:0] res, input logic [2:0] dst, input string name);
        wait_for(1, name);
        tick();
        i_res = res;
        r_res = res;
        i_dst = dst;
        r_dst = dst;
        i_finished = unit == 2'd1;
        r_finished = unit == 2'd2;
        tick();
        i_finished = 1'b0;
        r_finished = 1'b0;
    endtask
    task automatic run_vec(input int i);
        vec_t v;
        int w0, i0, r0;
        string n;
        v = vecs[i];
        n = $sformatf("v%0d", i);
        w0 = we_cnt;
        i0 = i_cnt;
        r0 = r_cnt;
        fetch(v.instr, n);
        if (v.drop_run) run = 1'b0;
        if (v.unit != 2'd0) finish_exec(v.unit, v.res, v.dst, n);
        if (v.mem != 2'd0) begin
            wait_for(2, {n, "_dmem"});
            chk({n, "_dmem_we"}, {31'd0, dmem_we}, {31'd0, v.mem == 2'd2});
            chk({n, "_dmem_addr"}, dmem_addr, v.res);
            if (v.mem == 2'd2) chk({n, "_dmem_wdata"}, dmem_wdata, 32'h1234_5678);
            repeat (3) tick();
            dmem_ack = 1'b1;
            dmem_rdata = v.rdata;
            tick();
            dmem_ack = 1'b0;
        end
        if (v.drop_run) begin
            repeat (6) tick();
            chk({n, "_idle_after_run_drop"}, {31'd0, imem_req}, 32'd0);
            run = 1'b1;
        end
        wait_for(0, {n, "_next"});
        chk({n, "_pc"}, pc, v.npc);
        chk({n, "_we_count"}, we_cnt - w0, {31'd0, v.we});
        if (v.we) begin
            chk({n, "_waddr"}, {27'd0, last_waddr}, {27'd0, v.waddr});
            chk({n, "_wdata"}, last_wdata, v.wdata);
        end
        chk({n, "_unit"}, {30'd0, r_cnt > r0, i_cnt > i0}, {30'd0, v.unit == 2'd2, v.unit == 2'd1});
    endtask
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
    initial begin
        int w0, n;
        vecs[0]  = '{32'h2009_0005, 32'd5,        DST_RT,    2'd1, 2'd0, 32'd0,         1'b1, 5'd9,  32'd5,         32'h004, 1'b0};
        vecs[1]  = '{32'h0800_0004, 32'd0,        DST_RT,    2'd0, 2'd0, 32'd0,         1'b0, 5'd0,  32'd0,         32'h010, 1'b0};
        vecs[2]  = '{32'h1000_FFFC, 32'd1,        DST_PC,    2'd1, 2'd0, 32'd0,         1'b0, 5'd0,  32'd0,         32'h004, 1'b0};
        vecs[3]  = '{32'h0800_0004, 32'd0,        DST_RT,    2'd0, 2'd0, 32'd0,         1'b0, 5'd0,  32'd0,         32'h010, 1'b0};
        vecs[4]  = '{32'h1000_FFFC, 32'd0,        DST_PC,    2'd1, 2'd0, 32'd0,         1'b0, 5'd0,  32'd0,         32'h014, 1'b0};
        vecs[5]  = '{32'h0800_0008, 32'd0,        DST_RT,    2'd0, 2'd0, 32'd0,         1'b0, 5'd0,  32'd0,         32'h020, 1'b0};
        vecs[6]  = '{32'h0800_0040, 32'd0,        DST_RT,    2'd0, 2'd0, 32'd0,         1'b0, 5'd0,  32'd0,         32'h100, 1'b0};
        vecs[7]  = '{32'h0129_5020, 32'd10,       DST_RD,    2'd2, 2'd0, 32'd0,         1'b1, 5'd10, 32'd10,        32'h104, 1'b0};
        vecs[8]  = '{32'h0C00_0080, 32'd0,        DST_RT,    2'd0, 2'd0, 32'd0,         1'b1, 5'd31, 32'h108,       32'h200, 1'b0};
        vecs[9]  = '{32'h2000_0007, 32'd7,        DST_RT,    2'd1, 2'd0, 32'd0,         1'b0, 5'd0,  32'd0,         32'h204, 1'b0};
        vecs[10] = '{32'h8D28_0000, 32'h100,      DST_MEM_L, 2'd1, 2'd1, 32'hDEAD_BEEF, 1'b1, 5'd8,  32'hDEAD_BEEF, 32'h208, 1'b1};
        vecs[11] = '{32'hAD28_0004, 32'h104,      DST_MEM_S, 2'd1, 2'd2, 32'd0,         1'b0, 5'd0,  32'd0,         32'h20C, 1'b0};
        clr = 1'b1;
        run = 1'b1;
        tick();
        tick();
        chk("reset_pc", pc, 32'd0);
        chk("reset_ir", ir, 32'd0);
        chk("reset_outs", {24'd0, imem_req, dmem_req, dmem_we, i_en, r_en, rf_we, halted, err}, 32'd0);
        clr = 1'b0;
        tick();
        chk("fetch_after_reset", {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < 12; i++) run_vec(i);
        fetch(32'h0000_000C, "syscall");
        tick();
        chk("syscall_halted", {31'd0, halted}, 32'd1);
        repeat (5) tick();
        chk("halt_hold", {28'd0, halted, imem_req, i_en, r_en}, 32'h8);
        chk("halt_pc", pc, 32'h20C);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        fetch(32'h2009_0005, "timeout");
        n = 0;
        for (int k = 0; k < 200 && !halted; k++) begin
            tick();
            if (i_en) n++;
        end
        chk("timeout_en_cycles", n, 32'd64);
        chk("timeout_flags", {29'd0, err, halted, i_en}, 32'h6);
        clr = 1'b1;
        tick();
        chk("clr_clears_err", {30'd0, err, halted}, 32'd0);
        clr = 1'b0;
        fetch(32'h8D28_0000, "clr_mem");
        finish_exec(2'd1, 32'h100, DST_MEM_L, "clr_mem");
        wait_for(2, "clr_mem_dmem");
        w0 = we_cnt;
        clr = 1'b1;
        run = 1'b0;
        tick();
        chk("clr_drops_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("clr_mem_pc", pc, 32'd0);
        clr = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_ack = 1'b0;
        repeat (3) tick();
        chk("late_ack_no_we", we_cnt - w0, 32'd0);
        chk("late_ack_idle", {30'd0, imem_req, dmem_req}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
